// File: rtl/x_move_sched_if.sv
// Control and status bundle for the horizontal movement scheduler.
// master drives the requests; slave is the scheduler side.
interface x_move_sched_if;
    logic        freeze;
    logic [1:0]  dir;
    logic        dash_req;
    logic        kb_req;
    logic        kb_dir;
    logic [11:0] x_begin;
    logic        tick;
    logic [1:0]  state;
    logic        facing;
    logic        at_left;
    logic        at_right;

    modport master (
        output freeze, dir, dash_req, kb_req, kb_dir,
        input  x_begin, tick, state, facing, at_left, at_right
    );

    modport slave (
        input  freeze, dir, dash_req, kb_req, kb_dir,
        output x_begin, tick, state, facing, at_left, at_right
    );
endinterface

// File: rtl/x_move_sched.sv
// Frame-tick driven sprite x scheduler: walk, timed dash and knockback with
// edge clamping; requests are latched between ticks and resolved on the tick.
module x_move_sched #(
    parameter int unsigned TICK_PERIOD = 2097152,
    parameter int unsigned X_RESET     = 270,
    parameter int unsigned X_MAX       = 540,
    parameter int unsigned WALK_STEP   = 2,
    parameter int unsigned DASH_STEP   = 6,
    parameter int unsigned DASH_TICKS  = 8,
    parameter int unsigned KB_STEP     = 4,
    parameter int unsigned KB_TICKS    = 6
) (
    input logic            clk,
    input logic            rst,
    x_move_sched_if.slave  bus
);
    localparam int unsigned TW    = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int unsigned DMAXT = (DASH_TICKS > KB_TICKS) ? DASH_TICKS : KB_TICKS;
    localparam int unsigned DW    = $clog2(DMAXT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WALK  = 2'b01,
        S_DASH  = 2'b10,
        S_KNOCK = 2'b11
    } state_t;

    logic [TW-1:0] r_tick_cnt;
    state_t        r_state;
    logic [11:0]   r_x;
    logic          r_facing;
    logic [DW-1:0] r_dur;
    logic          r_kb_pend;
    logic          r_kb_dir;
    logic          r_dash_pend;
    logic          r_dash_dir;

    logic w_tick;
    logic w_kb_pend;
    logic w_kb_dir;
    logic w_dash_pend;
    logic w_dir_valid;
    logic w_dir_right;
    logic w_dash_dir;

    // Pulses landing in the tick cycle itself are folded in here.
    assign w_tick      = (r_tick_cnt == TW'(TICK_PERIOD - 1));
    assign w_kb_pend   = r_kb_pend | bus.kb_req;
    assign w_kb_dir    = bus.kb_req ? bus.kb_dir : r_kb_dir;
    assign w_dash_pend = (r_dash_pend | bus.dash_req) && (r_state != S_KNOCK);
    assign w_dir_valid = bus.dir[1] ^ bus.dir[0];
    assign w_dir_right = bus.dir[0];
    assign w_dash_dir  = w_dir_valid ? w_dir_right : r_facing;

    function automatic logic [11:0] f_move(input logic [11:0] x, input logic right,
                                           input int unsigned step);
        logic [12:0] x13;
        logic [12:0] s13;
        x13 = {1'b0, x};
        s13 = 13'(step);
        if (right)
            return ((x13 + s13) > 13'(X_MAX)) ? 12'(X_MAX) : 12'(x13 + s13);
        else
            return (x13 < s13) ? '0 : 12'(x13 - s13);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt  <= '0;
            r_state     <= S_IDLE;
            r_x         <= 12'(X_RESET);
            r_facing    <= 1'b1;
            r_dur       <= '0;
            r_kb_pend   <= 1'b0;
            r_kb_dir    <= 1'b0;
            r_dash_pend <= 1'b0;
            r_dash_dir  <= 1'b1;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (w_tick && !bus.freeze) begin
                // Every processed tick consumes or drops both pending requests.
                r_kb_pend   <= 1'b0;
                r_dash_pend <= 1'b0;
                if (w_kb_pend) begin
                    r_state  <= S_KNOCK;
                    r_kb_dir <= w_kb_dir;
                    r_dur    <= DW'(KB_TICKS - 1);
                    r_x      <= f_move(r_x, w_kb_dir, KB_STEP);
                end else if (r_state == S_KNOCK) begin
                    r_x <= f_move(r_x, r_kb_dir, KB_STEP);
                    if (r_dur <= DW'(1)) begin
                        r_state <= S_IDLE;
                        r_dur   <= '0;
                    end else begin
                        r_dur <= r_dur - DW'(1);
                    end
                end else if (w_dash_pend) begin
                    r_state    <= S_DASH;
                    r_dash_dir <= w_dash_dir;
                    r_facing   <= w_dash_dir;
                    r_dur      <= DW'(DASH_TICKS - 1);
                    r_x        <= f_move(r_x, w_dash_dir, DASH_STEP);
                end else if (r_state == S_DASH) begin
                    r_x      <= f_move(r_x, r_dash_dir, DASH_STEP);
                    r_facing <= r_dash_dir;
                    if (r_dur <= DW'(1)) begin
                        r_state <= w_dir_valid ? S_WALK : S_IDLE;
                        r_dur   <= '0;
                    end else begin
                        r_dur <= r_dur - DW'(1);
                    end
                end else if (w_dir_valid) begin
                    r_state  <= S_WALK;
                    r_facing <= w_dir_right;
                    r_x      <= f_move(r_x, w_dir_right, WALK_STEP);
                end else begin
                    r_state <= S_IDLE;
                end
            end else begin
                if (bus.kb_req) begin
                    r_kb_pend <= 1'b1;
                    r_kb_dir  <= bus.kb_dir;
                end
                if (bus.dash_req && (r_state != S_KNOCK))
                    r_dash_pend <= 1'b1;
            end
        end
    end

    assign bus.x_begin  = r_x;
    assign bus.tick     = w_tick;
    assign bus.state    = r_state;
    assign bus.facing   = r_facing;
    assign bus.at_left  = (r_x == '0);
    assign bus.at_right = (r_x == 12'(X_MAX));
endmodule

// File: tb/tb_x_move_sched.sv
// Directed bench for x_move_sched with a 4-cycle frame tick: per-tick vector
// table followed by hand sequences for edge clamps and reset mid-knockback.
module tb_x_move_sched;
    logic clk;
    logic rst;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    x_move_sched_if bus_if ();

    x_move_sched #(
        .TICK_PERIOD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1);
    end

    typedef struct packed {
        logic        frz;
        logic [1:0]  dir;
        logic        dash;
        logic        kb;
        logic        kbd;
        logic [11:0] x;
        logic [1:0]  st;
        logic        fc;
    } vec_t;

    vec_t vecs [33];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Drives levels, pulses requests for one cycle, waits for the tick and
    // returns one cycle after the edge that processed it.
    task automatic run_tick(input logic frz, input logic [1:0] d, input logic dsh,
                            input logic kb, input logic kbd);
        int unsigned n;
        bit seen;
        n = 0;
        seen = 1'b0;
        bus_if.freeze   = frz;
        bus_if.dir      = d;
        bus_if.dash_req = dsh;
        bus_if.kb_req   = kb;
        bus_if.kb_dir   = kbd;
        while (!seen && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            bus_if.dash_req = 1'b0;
            bus_if.kb_req   = 1'b0;
            if (bus_if.tick) seen = 1'b1;
        end
        chk("tick_spacing", seen ? 32'(n) : 32'hFFFF_FFFF, 32'd3);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_xsf(input string nm, input int unsigned x, input int unsigned st,
                           input int unsigned fc);
        chk({nm, "_x"},      32'(bus_if.x_begin), 32'(x));
        chk({nm, "_state"},  32'(bus_if.state),   32'(st));
        chk({nm, "_facing"}, 32'(bus_if.facing),  32'(fc));
    endtask

    initial begin
        vecs = '{
            '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 12'd272, 2'b01, 1'b1},
            '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 12'd274, 2'b01, 1'b1},
            '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 12'd276, 2'b01, 1'b1},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 12'd274, 2'b01, 1'b0},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 12'd272, 2'b01, 1'b0},
            '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 12'd270, 2'b01, 1'b0},
            '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 12'd264, 2'b10, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd258, 2'b10, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd252, 2'b10, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd246, 2'b10, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd240, 2'b10, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd234, 2'b10, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd228, 2'b10, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd222, 2'b00, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd222, 2'b00, 1'b0},
            '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 12'd216, 2'b10, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd210, 2'b10, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 12'd214, 2'b11, 1'b0},
            '{1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 12'd218, 2'b11, 1'b0},
            '{1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 12'd222, 2'b11, 1'b0},
            '{1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 12'd226, 2'b11, 1'b0},
            '{1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 12'd230, 2'b11, 1'b0},
            '{1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 12'd234, 2'b00, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 12'd234, 2'b00, 1'b0},
            '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 12'd234, 2'b00, 1'b0},
            '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 12'd234, 2'b00, 1'b0},
            '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 12'd234, 2'b00, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd230, 2'b11, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd226, 2'b11, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd222, 2'b11, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd218, 2'b11, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd214, 2'b11, 1'b0},
            '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'd210, 2'b00, 1'b0}
        };

        rst             = 1'b1;
        bus_if.freeze   = 1'b0;
        bus_if.dir      = 2'b00;
        bus_if.dash_req = 1'b0;
        bus_if.kb_req   = 1'b0;
        bus_if.kb_dir   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_xsf("reset", 270, 0, 1);
        chk("reset_tick",     32'(bus_if.tick),     32'd0);
        chk("reset_at_left",  32'(bus_if.at_left),  32'd0);
        chk("reset_at_right", 32'(bus_if.at_right), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 33; i++) begin
            run_tick(vecs[i].frz, vecs[i].dir, vecs[i].dash, vecs[i].kb, vecs[i].kbd);
            chk_xsf($sformatf("row%0d", i), 32'(vecs[i].x), 32'(vecs[i].st), 32'(vecs[i].fc));
        end

        // Right edge clamp: 210 -> 536 by walking, then saturate at 540.
        for (int i = 0; i < 163; i++) run_tick(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        chk_xsf("walk536", 536, 1, 1);
        run_tick(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        chk_xsf("walk538", 538, 1, 1);
        chk("at_right_538", 32'(bus_if.at_right), 32'd0);
        run_tick(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        chk_xsf("walk540", 540, 1, 1);
        run_tick(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        chk_xsf("clamp540", 540, 1, 1);
        chk("at_right_540", 32'(bus_if.at_right), 32'd1);

        // Reset asserted mid-knockback at x=10, with requests pulsed alongside.
        for (int i = 0; i < 261; i++) run_tick(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        chk_xsf("walk18", 18, 1, 0);
        run_tick(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk_xsf("kb14", 14, 3, 0);
        run_tick(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_xsf("kb10", 10, 3, 0);
        rst             = 1'b1;
        bus_if.kb_req   = 1'b1;
        bus_if.dash_req = 1'b1;
        @(posedge clk);
        #1;
        chk_xsf("midkb_reset", 270, 0, 1);
        chk("midkb_reset_tick", 32'(bus_if.tick), 32'd0);
        rst             = 1'b0;
        bus_if.kb_req   = 1'b0;
        bus_if.dash_req = 1'b0;
        run_tick(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_xsf("pend_cleared", 270, 0, 1);

        // Left edge: dash clamped at 0 still lasts 8 ticks, then WALK as dir held.
        for (int i = 0; i < 133; i++) run_tick(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        chk_xsf("walk4", 4, 1, 0);
        run_tick(1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
        chk_xsf("dash_clamp0", 0, 2, 0);
        chk("at_left_0", 32'(bus_if.at_left), 32'd1);
        for (int i = 0; i < 6; i++) begin
            run_tick(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
            chk_xsf($sformatf("dash_edge%0d", i), 0, 2, 0);
        end
        run_tick(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        chk_xsf("dash_end_walk", 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
